// File: rtl/wb_merge_pkg.sv
// Shared pipeline definitions for the writeback merge block: register-index
// and data widths, the R15 index, and the queued-entry layout.
package wb_merge_pkg;

  localparam int REG_W    = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_PEND = 15;  // R0..R14 can ever be queued

  localparam logic [REG_W-1:0] R15_IDX = 4'hF;

  typedef struct packed {
    logic [REG_W-1:0]  wa;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Auxiliary result queue for wb_merge: strict FIFO with wrap-around pointers
// one bit wider than the index, per-slot valid bits, and a per-register
// "pending" summary of the queued destinations.
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  wb_entry_t           entry_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output wb_entry_t           head_o,
  output logic [NUM_PEND-1:0] pending_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push, do_pop;
  logic [(1<<REG_W)-1:0] pend_all;

  // Occupancy flags, guarded push/pop and next pointer/valid state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    // Clear before set: on a full queue the popped and pushed slot coincide.
    if (do_pop) begin
      rd_ptr_d                    = rd_ptr_q + PTR_ONE;
      valid_d[rd_ptr_q[AW-1:0]]   = 1'b0;
    end
    if (do_push) begin
      wr_ptr_d                    = wr_ptr_q + PTR_ONE;
      valid_d[wr_ptr_q[AW-1:0]]   = 1'b1;
    end
  end

  // Head entry and which registers have a queued, unwritten result.
  always_comb begin
    head_o   = mem_q[rd_ptr_q[AW-1:0]];
    pend_all = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pend_all[mem_q[i].wa] = 1'b1;
    end
    pending_o = pend_all[NUM_PEND-1:0];
  end

  // Pointer and valid-bit registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the valid bits and pointers decide what is live.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/wb_merge.sv
// Register-file writeback merge: the pipeline result goes straight through,
// long-latency (aux) results wait in a FIFO and drain in idle pipe cycles.
// Optional starvation guard: define WB_MERGE_STARVE_GUARD_EN to force a
// one-cycle stall and drain after STARVE_LIMIT full-and-blocked cycles.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pipe_we,
  input  logic [REG_W-1:0]    pipe_wa,
  input  logic [DATA_W-1:0]   pipe_wd,
  input  logic                aux_valid,
  output logic                aux_ready,
  input  logic [REG_W-1:0]    aux_wa,
  input  logic [DATA_W-1:0]   aux_wd,
  output logic                we3,
  output logic [REG_W-1:0]    wa3,
  output logic [DATA_W-1:0]   wd3,
  output logic [NUM_PEND-1:0] pending,
  output logic                stall,
  output logic                r15_err
);

  logic                full, empty, push, pop, accept, force_drain;
  logic                r15_err_q, r15_err_d;
  wb_entry_t           head, entry;
  logic [NUM_PEND-1:0] q_pending;

`ifdef WB_MERGE_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          blocked;

  // Count consecutive full-and-blocked cycles; fire a forced drain on the last.
  always_comb begin
    blocked      = full && pipe_we;
    force_drain  = !reset && blocked && (starve_cnt_q == CW'(STARVE_LIMIT - 1));
    starve_cnt_d = '0;
    if (blocked && !force_drain) starve_cnt_d = starve_cnt_q + CW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_drain = 1'b0;
`endif

  assign stall = force_drain;

  // Queue control, handshake and register-file write selection.
  always_comb begin
    pop       = !reset && !empty && (!pipe_we || force_drain);
    aux_ready = !reset && (!full || pop);
    accept    = aux_valid && aux_ready;
    push      = accept && (aux_wa != R15_IDX);
    r15_err_d = r15_err_q || (accept && (aux_wa == R15_IDX));
    entry     = '{wa: aux_wa, wd: aux_wd};
    we3       = 1'b0;
    wa3       = '0;
    wd3       = '0;
    if (pop) begin
      we3 = 1'b1;
      wa3 = head.wa;
      wd3 = head.wd;
    end else if (!reset && pipe_we && !force_drain && (pipe_wa != R15_IDX)) begin
      we3 = 1'b1;
      wa3 = pipe_wa;
      wd3 = pipe_wd;
    end
    pending = reset ? '0 : q_pending;
  end

  // Sticky record of a dropped aux write to R15.
  always_ff @(posedge clk) begin
    if (reset) r15_err_q <= 1'b0;
    else       r15_err_q <= r15_err_d;
  end

  assign r15_err = r15_err_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .entry_i   (entry),
    .pop_i     (pop),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head),
    .pending_o (q_pending)
  );

endmodule
